// File: rtl/lenet_start_ctrl.sv
// rtl/lenet_start_ctrl.sv - push-button launch controller for the LeNet inference core
//
// Synchronizes and debounces a raw start button, launches the core with a
// one-cycle start pulse and a latched image select, waits for the core's
// finish edge and holds the captured result until the next press.
//
// Optional feature: define LENET_TIMEOUT_EN to add a RUN-state watchdog that
// ends a run after TIMEOUT_CYCLES cycles with timeout=1 and a 4'hF/2'b11
// result. Without it the core is waited on indefinitely and timeout is 0.
//
// Ports:
//   sys_clk       in   single clock
//   sys_rst_n     in   asynchronous active-low reset
//   btn_start     in   raw bouncing push-button
//   sw_graph[4:0] in   raw image-select switches
//   lenet_finish  in   inference-done level from the core
//   max_index[3:0] in  classified digit from the core
//   right[1:0]    in   correctness code from the core
//   start         out  one-cycle launch pulse
//   graph[4:0]    out  image select, held from launch to next launch
//   busy          out  high in LAUNCH and RUN
//   result_valid  out  high in DONE
//   result_index[3:0] out captured digit (4'hF on timeout)
//   result_right[1:0] out captured code (2'b11 on timeout)
//   timeout       out  high in DONE when the watchdog ended the run

module lenet_start_ctrl #(
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000,
   parameter logic [31:0] TIMEOUT_CYCLES  = 32'd50000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       btn_start,
   input  logic [4:0] sw_graph,
   input  logic       lenet_finish,
   input  logic [3:0] max_index,
   input  logic [1:0] right,
   output logic       start,
   output logic [4:0] graph,
   output logic       busy,
   output logic       result_valid,
   output logic [3:0] result_index,
   output logic [1:0] result_right,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

   state_t      state;
   logic        btn_meta, btn_sync;
   logic [4:0]  sw_meta, sw_sync;
   logic        fin_meta, fin_sync, fin_prev;
   logic        db_level, db_prev;
   logic [19:0] db_cnt;
   logic        press;
   logic        fin_rise;

`ifdef LENET_TIMEOUT_EN
   logic [31:0] run_cnt;
   logic        timeout_r;
   assign timeout = timeout_r;
`else
   logic        unused_timeout_param;
   assign unused_timeout_param = ^TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // Two-flop synchronizers; fin_prev gives edge detection so a finish level
   // left high from a previous run never counts as a new completion.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         sw_meta  <= 5'd0;
         sw_sync  <= 5'd0;
         fin_meta <= 1'b0;
         fin_sync <= 1'b0;
         fin_prev <= 1'b0;
      end else begin
         btn_meta <= btn_start;
         btn_sync <= btn_meta;
         sw_meta  <= sw_graph;
         sw_sync  <= sw_meta;
         fin_meta <= lenet_finish;
         fin_sync <= fin_meta;
         fin_prev <= fin_sync;
      end
   end

   // Debounce: the level follows the button only after DEBOUNCE_CYCLES
   // consecutive mismatching cycles; any agreeing cycle restarts the count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         db_level <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= 20'd0;
      end else begin
         db_prev <= db_level;
         if (btn_sync != db_level) begin
            if (db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
               db_level <= btn_sync;
               db_cnt   <= 20'd0;
            end else begin
               db_cnt <= db_cnt + 20'd1;
            end
         end else begin
            db_cnt <= 20'd0;
         end
      end
   end

   assign press    = db_level & ~db_prev;
   assign fin_rise = fin_sync & ~fin_prev;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= IDLE;
         start        <= 1'b0;
         graph        <= 5'd0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         result_index <= 4'd0;
         result_right <= 2'd0;
`ifdef LENET_TIMEOUT_EN
         run_cnt      <= 32'd0;
         timeout_r    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (press) begin
                  state        <= LAUNCH;
                  start        <= 1'b1;
                  busy         <= 1'b1;
                  graph        <= sw_sync;
                  result_valid <= 1'b0;
`ifdef LENET_TIMEOUT_EN
                  timeout_r    <= 1'b0;
`endif
               end
            end
            LAUNCH: begin
               state <= RUN;
               start <= 1'b0;
`ifdef LENET_TIMEOUT_EN
               run_cnt <= 32'd0;
`endif
            end
            RUN: begin
               // A finish edge takes priority over both a press (ignored in
               // RUN anyway) and a coincident watchdog expiry.
               if (fin_rise) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
                  result_index <= max_index;
                  result_right <= right;
               end
`ifdef LENET_TIMEOUT_EN
               else if (run_cnt == TIMEOUT_CYCLES - 32'd1) begin
                  state        <= DONE;
                  busy         <= 1'b0;
                  result_valid <= 1'b1;
                  result_index <= 4'hF;
                  result_right <= 2'b11;
                  timeout_r    <= 1'b1;
               end else begin
                  run_cnt <= run_cnt + 32'd1;
               end
`endif
            end
            default: begin
               state <= IDLE;
               start <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lenet_start_ctrl.sv
// tb/tb_lenet_start_ctrl.sv - self-checking bench for lenet_start_ctrl

module tb_lenet_start_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn = 1'b0;
   logic [4:0] sw = 5'd0;
   logic       fin = 1'b0;
   logic [3:0] mi = 4'd0;
   logic [1:0] rt = 2'd0;
   logic       start, busy, result_valid, timeout;
   logic [4:0] graph;
   logic [3:0] result_index;
   logic [1:0] result_right;

   int total = 0;
   int bad = 0;
   logic [6:0] exp_q[$];   // {index, right, timeout}

   lenet_start_ctrl #(.DEBOUNCE_CYCLES(20'd4), .TIMEOUT_CYCLES(32'd100)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .btn_start(btn), .sw_graph(sw),
      .lenet_finish(fin), .max_index(mi), .right(rt),
      .start(start), .graph(graph), .busy(busy), .result_valid(result_valid),
      .result_index(result_index), .result_right(result_right), .timeout(timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && start) begin
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_without_busy: busy=%b required 1", busy);
         end
      end
   end

   task automatic press(input int hold, input int window, output int starts,
                        output logic [4:0] g_at, output logic b_at);
      starts = 0; g_at = 5'd0; b_at = 1'b0;
      btn = 1'b1;
      for (int i = 0; i < window; i++) begin
         @(negedge clk);
         if (i == hold) btn = 1'b0;
         if (start) begin
            if (starts == 0) begin g_at = graph; b_at = busy; end
            starts++;
         end
      end
      btn = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total += 7;
      if (start !== 1'b0)        begin bad++; $display("FAIL rst_start: %b required 0", start); end
      if (graph !== 5'd0)        begin bad++; $display("FAIL rst_graph: %0d required 0", graph); end
      if (busy !== 1'b0)         begin bad++; $display("FAIL rst_busy: %b required 0", busy); end
      if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: %b required 0", result_valid); end
      if (result_index !== 4'd0) begin bad++; $display("FAIL rst_index: %0d required 0", result_index); end
      if (result_right !== 2'd0) begin bad++; $display("FAIL rst_right: %0d required 0", result_right); end
      if (timeout !== 1'b0)      begin bad++; $display("FAIL rst_timeout: %b required 0", timeout); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_launch;
      int n; logic [4:0] g; logic b;
      sw = 5'd7;
      press(10, 30, n, g, b);
      total += 4;
      if (n !== 1)     begin bad++; $display("FAIL launch_starts: %0d required 1", n); end
      if (g !== 5'd7)  begin bad++; $display("FAIL launch_graph: %0d required 7", g); end
      if (b !== 1'b1)  begin bad++; $display("FAIL launch_busy: %b required 1", b); end
      sw = 5'd9;
      repeat (5) @(negedge clk);
      if (graph !== 5'd7) begin bad++; $display("FAIL graph_held: %0d required 7", graph); end
   endtask

   task automatic test_finish;
      int n; logic [4:0] g; logic b; logic [6:0] e; bit seen;
      press(10, 30, n, g, b);
      total += 2;
      if (n !== 0)        begin bad++; $display("FAIL run_press_ignored: starts=%0d required 0", n); end
      if (busy !== 1'b1)  begin bad++; $display("FAIL still_run: busy=%b required 1", busy); end
      mi = 4'd3; rt = 2'b01;
      exp_q.push_back({4'd3, 2'b01, 1'b0});
      fin = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (result_valid) seen = 1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL finish_wait: result_valid=0 required 1"); end
      else begin
         e = exp_q.pop_front();
         total += 4;
         if (result_index !== e[6:3]) begin bad++; $display("FAIL fin_index: %0d required %0d", result_index, e[6:3]); end
         if (result_right !== e[2:1]) begin bad++; $display("FAIL fin_right: %0d required %0d", result_right, e[2:1]); end
         if (timeout !== e[0])        begin bad++; $display("FAIL fin_timeout: %b required %b", timeout, e[0]); end
         if (busy !== 1'b0)           begin bad++; $display("FAIL fin_busy: %b required 0", busy); end
      end
      mi = 4'd0; rt = 2'd0;
   endtask

   task automatic test_bounce;
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         btn = ((i / 2) % 2 == 0);
         @(negedge clk);
         if (start) n++;
      end
      btn = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (start) n++;
      end
      total += 3;
      if (n !== 0)               begin bad++; $display("FAIL bounce_starts: %0d required 0", n); end
      if (result_valid !== 1'b1) begin bad++; $display("FAIL done_held_valid: %b required 1", result_valid); end
      if (result_index !== 4'd3) begin bad++; $display("FAIL done_held_index: %0d required 3", result_index); end
   endtask

   task automatic test_stale_finish;
      int n; logic [4:0] g; logic b; logic [6:0] e; bit seen;
      sw = 5'd12;
      press(10, 40, n, g, b);   // lenet_finish still high from the last run
      total += 4;
      if (n !== 1)               begin bad++; $display("FAIL stale_starts: %0d required 1", n); end
      if (g !== 5'd12)           begin bad++; $display("FAIL stale_graph: %0d required 12", g); end
      if (busy !== 1'b1)         begin bad++; $display("FAIL stale_busy: %b required 1", busy); end
      if (result_valid !== 1'b0) begin bad++; $display("FAIL stale_valid: %b required 0", result_valid); end
      fin = 1'b0;
      repeat (6) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL stale_fall_busy: %b required 1", busy); end
      mi = 4'd5; rt = 2'b10;
      exp_q.push_back({4'd5, 2'b10, 1'b0});
      fin = 1'b1;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (result_valid) seen = 1;
      end
      total++;
      if (!seen) begin bad++; $display("FAIL stale_wait: result_valid=0 required 1"); end
      else begin
         e = exp_q.pop_front();
         total += 3;
         if (result_index !== e[6:3]) begin bad++; $display("FAIL stale_index: %0d required %0d", result_index, e[6:3]); end
         if (result_right !== e[2:1]) begin bad++; $display("FAIL stale_right: %0d required %0d", result_right, e[2:1]); end
         if (timeout !== e[0])        begin bad++; $display("FAIL stale_timeout: %b required %b", timeout, e[0]); end
      end
      fin = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_timeout;
      int k = -1;
      int r = -1;
      logic [6:0] e;
      btn = 1'b1;
      for (int i = 0; i < 220; i++) begin
         @(negedge clk);
         if (i == 10) btn = 1'b0;
         if (start && k < 0) k = i;
         if (result_valid && k >= 0 && r < 0) r = i;
      end
      total++;
      if (k < 0) begin bad++; $display("FAIL to_launch: no start pulse"); end
`ifdef LENET_TIMEOUT_EN
      exp_q.push_back({4'hF, 2'b11, 1'b1});
      total++;
      if (r - k !== 101) begin bad++; $display("FAIL to_latency: %0d required 101", r - k); end
      e = exp_q.pop_front();
      total += 3;
      if (result_index !== e[6:3]) begin bad++; $display("FAIL to_index: %0d required %0d", result_index, e[6:3]); end
      if (result_right !== e[2:1]) begin bad++; $display("FAIL to_right: %0d required %0d", result_right, e[2:1]); end
      if (timeout !== e[0])        begin bad++; $display("FAIL to_flag: %b required %b", timeout, e[0]); end
`else
      e = 7'd0;
      total += 3;
      if (r !== -1)              begin bad++; $display("FAIL nowd_done: result at %0d required none", r); end
      if (busy !== 1'b1)         begin bad++; $display("FAIL nowd_busy: %b required 1", busy); end
      if (timeout !== 1'b0)      begin bad++; $display("FAIL nowd_timeout: %b required 0 (e=%0d)", timeout, e); end
`endif
   endtask

   task automatic test_reset_midrun;
      int n; logic [4:0] g; logic b;
      press(10, 30, n, g, b);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: %b required 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      total += 5;
      if (busy !== 1'b0)         begin bad++; $display("FAIL mid_busy: %b required 0", busy); end
      if (start !== 1'b0)        begin bad++; $display("FAIL mid_start: %b required 0", start); end
      if (graph !== 5'd0)        begin bad++; $display("FAIL mid_graph: %0d required 0", graph); end
      if (result_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: %b required 0", result_valid); end
      if (result_index !== 4'd0) begin bad++; $display("FAIL mid_index: %0d required 0", result_index); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (start) n++;
      end
      total++;
      if (n !== 0) begin bad++; $display("FAIL mid_no_start: %0d required 0", n); end
   endtask

   task automatic test_held_through_reset;
      int n = 0;
      rst_n = 1'b0;
      btn = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (start) n++;
      end
      btn = 1'b0;
      total++;
      if (n !== 1) begin bad++; $display("FAIL held_reset_starts: %0d required 1", n); end
   endtask

   initial begin
      test_reset();
      test_launch();
      test_finish();
      test_bounce();
      test_stale_finish();
      test_timeout();
      test_reset_midrun();
      test_held_through_reset();
      total++;
      if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left: %0d required 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
